pulse_sync_multi: RTL and testbench
===================================

Name: pulse_sync_multi

Overview:
Multi-channel, lossless pulse synchronizer from the in_clk domain to the out_clk domain. Each channel uses a toggle request/acknowledge handshake with a saturating backlog counter in the source domain. In-pulses that arrive faster than the crossing can carry are queued and delivered later, not dropped. It is the generalised successor of the single-channel toggle pulse synchronizer: independent channels, configurable synchronizer depth, backlog counting, busy and overflow reporting.

Parameters:
NUM_CH, 1, number of independent pulse channels (1..32)
CNT_W, 4, width of each channel's backlog counter (1..16); max queued pulses = 2^CNT_W-1
SYNC_STAGES, 2, flop stages in every synchronizer chain, both directions (2..4)

Ports:
in_clk  input  1  source-domain clock
rst_n  input  1  reset, asynchronous, active-low; common to both domains; deassertion is synchronised externally to each clock
out_clk  input  1  destination-domain clock
in_pulse  input  NUM_CH  one in_clk-cycle event per set bit; every in_clk cycle it is high counts as one event
ovf_clr  input  1  in_clk domain; clears all overflow flags
busy  output  NUM_CH  in_clk domain; channel has a transfer in flight or a nonzero backlog
overflow  output  NUM_CH  in_clk domain; sticky, an event was lost on this channel
out_pulse  output  NUM_CH  out_clk domain; one out_clk-cycle pulse per delivered event

Behaviour:
- Reset (rst_n low, asynchronous) clears the following: req, ack, pending, overflow, all sync flops, req_last. Outputs during reset: busy=0, overflow=0, out_pulse=0. A reset asserted mid-transfer discards any in-flight or queued events. No spurious out_pulse is produced after release.
- Per channel, source side (in_clk):
  - req toggle flop.
  - ack_sync: ack passed through SYNC_STAGES flops.
  - pending: CNT_W bits.
  - idle = (req == ack_sync).
- Launch: at an in_clk edge where idle=1 and (pending!=0 or in_pulse=1), req toggles.
  - The backlog is served first. If pending!=0, pending decrements, and a simultaneous in_pulse is added to it, so the net count is unchanged.
  - If pending=0, the in_pulse launches directly and pending stays 0.
- Enqueue: at an edge where in_pulse=1 and the pulse is not launched directly, pending increments.
  - If pending is already 2^CNT_W-1, it stays saturated and overflow sets.
- overflow: sticky. ovf_clr=1 clears it on the next edge. If ovf_clr coincides with a new overflow event, set wins.
- busy = ~idle | (pending!=0), combinational from registers.
- Destination side (out_clk):
  - req passes through SYNC_STAGES flops to give req_sync.
  - req_last <= req_sync.
  - out_pulse = req_sync ^ req_last, which is high for exactly one out_clk cycle per req toggle.
  - ack is driven by req_last, a registered signal, back to the source.
- Latency:
  - out_pulse rises after the SYNC_STAGES-th out_clk edge following the req toggle (1 out_clk cycle of jitter).
  - Minimum round trip per event on a channel: about SYNC_STAGES+1 out_clk cycles plus SYNC_STAGES+1 in_clk cycles.
- Channels are fully independent. Simultaneous events on different channels never interact.
- Only single-bit toggle signals cross domains. No multi-bit values cross domains.
- Conservation: with no overflow, the count of out_pulse per channel equals the count of in_pulse cycles once busy=0.
- Clock ratio: either clock may be faster, with any phase relation.

Test Plan:
1. NUM_CH=1, SYNC_STAGES=2, in_clk 100MHz, out_clk 75MHz; single 1-cycle in_pulse -> exactly one out_pulse, 2-3 out_clk cycles after req toggle; busy high from the next in_clk edge until ack_sync returns, then 0.
2. CNT_W=2; in_pulse held high 5 consecutive in_clk cycles:
   - 1st launches directly; pending reaches 3; overflow=1 on the 5th.
   - Exactly 4 out_pulse are delivered, then busy=0.
   - ovf_clr -> overflow=0.
3. CNT_W=4; 10 back-to-back in_pulse with out_clk 4x slower than in_clk -> 10 out_pulse, each 1 out_clk cycle wide, none merged; overflow stays 0.
4. NUM_CH=4; channels 0 and 3 pulsed on the same in_clk cycle, channel 1 pulsed 3 cycles later, channel 2 idle -> out_pulse[0], out_pulse[1] and out_pulse[3] fire once each; out_pulse[2] never fires.
5. rst_n asserted while pending=2 and req in flight -> all outputs 0 immediately; after release, no out_pulse appears within 20 out_clk cycles; a new in_pulse then delivers exactly one out_pulse.
6. Randomised pulse density, in_clk/out_clk ratios 1:3, 1:1 and 3:1, SYNC_STAGES=3 -> per-channel in/out counts equal whenever overflow=0.

Source files
------------

// File: rtl/pulse_sync_multi.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : pulse_sync_multi
// Description : Multi-channel lossless pulse synchronizer from in_clk to
//               out_clk. Each channel carries events across the boundary with
//               a toggle request/acknowledge handshake. Events that arrive
//               while a transfer is in flight go into a saturating backlog
//               counter in the source domain and are delivered later.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   in_clk     in   1       source-domain clock
//   rst_n      in   1       asynchronous active-low reset, both domains
//   out_clk    in   1       destination-domain clock
//   in_pulse   in   NUM_CH  one event per set bit per in_clk cycle
//   ovf_clr    in   1       in_clk domain, clears every overflow flag
//   busy       out  NUM_CH  in_clk domain, transfer in flight or backlog != 0
//   overflow   out  NUM_CH  in_clk domain, sticky, an event was lost
//   out_pulse  out  NUM_CH  out_clk domain, one-cycle pulse per event
// ============================================================================
module pulse_sync_multi #(
   parameter int NUM_CH      = 1,  // independent channels, 1..32
   parameter int CNT_W       = 4,  // backlog counter width, 1..16
   parameter int SYNC_STAGES = 2   // synchronizer depth, both directions, 2..4
) (
   input  logic              in_clk,
   input  logic              rst_n,
   input  logic              out_clk,
   input  logic [NUM_CH-1:0] in_pulse,
   input  logic              ovf_clr,
   output logic [NUM_CH-1:0] busy,
   output logic [NUM_CH-1:0] overflow,
   output logic [NUM_CH-1:0] out_pulse
);

   localparam logic [CNT_W-1:0] c_PEND_ONE = CNT_W'(1);

   // -------------------------------------------------------------------------
   // One fully independent crossing per channel. Only the single-bit req and
   // ack toggles cross between the two domains.
   // -------------------------------------------------------------------------
   for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch

      // ---------------------------------------------------------------------
      // Source domain (in_clk) state
      // ---------------------------------------------------------------------
      logic                   req_q;
      logic                   req_d;
      logic [SYNC_STAGES-1:0] ack_sync_q;
      logic [SYNC_STAGES-1:0] ack_sync_d;
      logic [CNT_W-1:0]       pend_q;
      logic [CNT_W-1:0]       pend_d;
      logic                   ovf_q;
      logic                   ovf_d;

      // ---------------------------------------------------------------------
      // Destination domain (out_clk) state
      // ---------------------------------------------------------------------
      logic [SYNC_STAGES-1:0] req_sync_q;
      logic [SYNC_STAGES-1:0] req_sync_d;
      logic                   req_last_q;
      logic                   req_last_d;

      // ---------------------------------------------------------------------
      // Source-domain decode
      // ---------------------------------------------------------------------
      logic w_ack_s;      // acknowledge after the synchronizer chain
      logic w_idle;       // no toggle outstanding
      logic w_pend_nz;    // backlog holds at least one event
      logic w_pend_full;  // backlog saturated
      logic w_launch;     // req toggles at this edge
      logic w_lost;       // this edge's event cannot be stored

      assign w_ack_s     = ack_sync_q[SYNC_STAGES-1];
      assign w_idle      = (req_q == w_ack_s);
      assign w_pend_nz   = |pend_q;
      assign w_pend_full = &pend_q;

      // A free handshake is used either by the oldest queued event or, when
      // the queue is empty, directly by the incoming pulse.
      assign w_launch    = w_idle & (w_pend_nz | in_pulse[ch]);

      // An event is lost only when it has to be queued and the queue is full.
      // If the handshake drains one queued event at the same edge the new
      // pulse takes its slot, so nothing is lost even with a full queue.
      assign w_lost      = in_pulse[ch] & ~w_launch & w_pend_full;

      // ---------------------------------------------------------------------
      // Source-domain next state
      // ---------------------------------------------------------------------
      always_comb begin
         req_d      = req_q ^ w_launch;
         ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], req_last_q};
         pend_d     = pend_q;
         ovf_d      = ovf_q;

         if (w_launch && w_pend_nz) begin
            // Backlog served first; a coinciding pulse refills the slot so
            // the count only drops when no new pulse arrives.
            if (!in_pulse[ch]) begin
               pend_d = pend_q - c_PEND_ONE;
            end
         end else if (in_pulse[ch] && !w_launch && !w_pend_full) begin
            pend_d = pend_q + c_PEND_ONE;
         end

         // Sticky flag: a clear request loses against a new loss event.
         if (w_lost) begin
            ovf_d = 1'b1;
         end else if (ovf_clr) begin
            ovf_d = 1'b0;
         end
      end

      always_ff @(posedge in_clk or negedge rst_n) begin
         if (!rst_n) begin
            req_q      <= 1'b0;
            ack_sync_q <= '0;
            pend_q     <= '0;
            ovf_q      <= 1'b0;
         end else begin
            req_q      <= req_d;
            ack_sync_q <= ack_sync_d;
            pend_q     <= pend_d;
            ovf_q      <= ovf_d;
         end
      end

      // ---------------------------------------------------------------------
      // Destination-domain next state. req_last doubles as the acknowledge:
      // it is registered, so only a clean flop output crosses back.
      // ---------------------------------------------------------------------
      always_comb begin
         req_sync_d = {req_sync_q[SYNC_STAGES-2:0], req_q};
         req_last_d = req_sync_q[SYNC_STAGES-1];
      end

      always_ff @(posedge out_clk or negedge rst_n) begin
         if (!rst_n) begin
            req_sync_q <= '0;
            req_last_q <= 1'b0;
         end else begin
            req_sync_q <= req_sync_d;
            req_last_q <= req_last_d;
         end
      end

      // ---------------------------------------------------------------------
      // Outputs, all decoded from registers only
      // ---------------------------------------------------------------------
      assign busy[ch]      = ~w_idle | w_pend_nz;
      assign overflow[ch]  = ovf_q;

      // Every req toggle shows up as exactly one cycle of disagreement
      // between the last synchronizer stage and its delayed copy.
      assign out_pulse[ch] = req_sync_q[SYNC_STAGES-1] ^ req_last_q;

   end : g_ch

endmodule : pulse_sync_multi
`default_nettype wire

// File: tb/tb_pulse_sync_multi.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_pulse_sync_multi
// Description : Self-checking bench for pulse_sync_multi. An event-count model
//               (events in, events out, loss allowed only when the backlog
//               could be full) is compared every in_clk cycle, alongside
//               hand-computed expectations for the directed scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_sync_multi;

   localparam int NUM_CH      = 4;
   localparam int CNT_W       = 4;
   localparam int SYNC_STAGES = 3;
   localparam int MAXQ        = (1 << CNT_W) - 1;

   logic              in_clk   = 1'b0;
   logic              out_clk  = 1'b0;
   logic              rst_n    = 1'b0;
   logic              ovf_clr  = 1'b0;
   logic [NUM_CH-1:0] in_pulse = '0;
   logic [NUM_CH-1:0] busy;
   logic [NUM_CH-1:0] overflow;
   logic [NUM_CH-1:0] out_pulse;

   realtime out_half = 6.5;

   pulse_sync_multi #(
      .NUM_CH     (NUM_CH),
      .CNT_W      (CNT_W),
      .SYNC_STAGES(SYNC_STAGES)
   ) u_dut (
      .in_clk   (in_clk),
      .rst_n    (rst_n),
      .out_clk  (out_clk),
      .in_pulse (in_pulse),
      .ovf_clr  (ovf_clr),
      .busy     (busy),
      .overflow (overflow),
      .out_pulse(out_pulse)
   );

   always #5 in_clk = ~in_clk;

   always begin
      #(out_half);
      out_clk = ~out_clk;
   end

   // ------------------------------------------------------------------------
   // Bookkeeping
   // ------------------------------------------------------------------------
   int errors  = 0;
   int checks  = 0;
   int cyc_err = 0;
   int cyc_chk = 0;

   int in_cnt  [NUM_CH];
   int out_cnt [NUM_CH];
   int merged  [NUM_CH];
   bit prev_out[NUM_CH];
   bit ovf_poss[NUM_CH];   // a loss is permitted since the last clear
   bit ovf_ever[NUM_CH];   // a loss was permitted at some point since reset
   int out_edges = 0;

   function automatic int fail_if(input bit ok, input string name,
                                  input longint act, input longint exp);
      if (!ok) begin
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
         return 1;
      end
      return 0;
   endfunction

   task automatic chk(input bit ok, input string name,
                      input longint act, input longint exp);
      checks++;
      errors += fail_if(ok, name, act, exp);
   endtask

   // ------------------------------------------------------------------------
   // Source-side model: count events, decide whether a loss is permissible.
   // Events held in the source never exceed (in - delivered so far), so a
   // loss can only be legal once that difference has reached the capacity.
   // ------------------------------------------------------------------------
   always @(posedge in_clk) begin
      if (!rst_n) begin
         for (int ch = 0; ch < NUM_CH; ch++) begin
            in_cnt[ch]   = 0;
            ovf_poss[ch] = 1'b0;
            ovf_ever[ch] = 1'b0;
         end
      end else begin
         for (int ch = 0; ch < NUM_CH; ch++) begin
            if (in_pulse[ch] && (in_cnt[ch] - out_cnt[ch] >= MAXQ)) begin
               ovf_poss[ch] = 1'b1;
               ovf_ever[ch] = 1'b1;
            end else if (ovf_clr) begin
               ovf_poss[ch] = 1'b0;
            end
            if (in_pulse[ch]) in_cnt[ch]++;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Destination-side model: count delivered events, note merged pulses
   // ------------------------------------------------------------------------
   always @(posedge out_clk) out_edges++;

   always @(negedge out_clk) begin
      if (!rst_n) begin
         for (int ch = 0; ch < NUM_CH; ch++) begin
            out_cnt[ch]  = 0;
            merged[ch]   = 0;
            prev_out[ch] = 1'b0;
         end
      end else begin
         for (int ch = 0; ch < NUM_CH; ch++) begin
            if (out_pulse[ch]) begin
               if (prev_out[ch]) merged[ch]++;
               out_cnt[ch]++;
            end
            prev_out[ch] = out_pulse[ch];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Per-cycle comparison against the model
   // ------------------------------------------------------------------------
   always @(negedge in_clk) begin
      if (rst_n) begin
         for (int ch = 0; ch < NUM_CH; ch++) begin
            if (!busy[ch]) begin
               cyc_chk++;
               if (!ovf_ever[ch])
                  cyc_err += fail_if(out_cnt[ch] == in_cnt[ch], "idle_conservation",
                                     out_cnt[ch], in_cnt[ch]);
               else
                  cyc_err += fail_if(out_cnt[ch] <= in_cnt[ch], "idle_out_le_in",
                                     out_cnt[ch], in_cnt[ch]);
            end
            if (overflow[ch]) begin
               cyc_chk++;
               cyc_err += fail_if(ovf_poss[ch], "overflow_justified", 1, 0);
            end
            cyc_chk++;
            cyc_err += fail_if(merged[ch] == 0, "out_pulse_width", merged[ch], 0);
         end
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus helpers (inputs change 1 ns after the in_clk rising edge)
   // ------------------------------------------------------------------------
   task automatic step();
      @(posedge in_clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      in_pulse = '0;
      ovf_clr  = 1'b0;
      repeat (3) @(posedge in_clk);
      repeat (2) @(negedge out_clk);
      @(negedge in_clk);
      #1 rst_n = 1'b1;
      step();
      step();
   endtask

   task automatic wait_idle(input int bound, input string name);
      int n = 0;
      while (busy != '0 && n < bound) begin
         step();
         n++;
      end
      chk(busy == '0, name, busy, 0);
      repeat (4) step();
   endtask

   // ------------------------------------------------------------------------
   // Scenarios
   // ------------------------------------------------------------------------
   int e0, lat, n;
   int exp4[NUM_CH];
   int dens;

   initial begin
      // Reset state
      do_reset();
      chk({busy, overflow, out_pulse} == '0, "reset_outputs",
          {busy, overflow, out_pulse}, 0);

      // Single pulse: busy next edge, latency SYNC_STAGES (+1 jitter)
      in_pulse = 4'b0001;
      @(posedge in_clk);
      e0 = out_edges;
      #1 in_pulse = '0;
      @(negedge in_clk);
      chk(busy == 4'b0001, "t1_busy_next_edge", busy, 1);
      n = 0;
      while (!out_pulse[0] && n < 20) begin
         @(negedge out_clk);
         n++;
      end
      chk(out_pulse[0] == 1'b1, "t1_out_seen", out_pulse[0], 1);
      lat = out_edges - e0;
      chk(lat == SYNC_STAGES || lat == SYNC_STAGES + 1, "t1_latency", lat, SYNC_STAGES);
      step();
      wait_idle(200, "t1_drain");
      chk(out_cnt[0] == 1, "t1_count", out_cnt[0], 1);

      // Saturation: 17 back-to-back events, out_clk far slower
      out_half = 50.0;
      do_reset();
      in_pulse = 4'b0001;
      repeat (16) step();
      chk(overflow[0] == 1'b0, "t2_no_ovf_at_16", overflow[0], 0);
      step();
      in_pulse = '0;
      chk(overflow[0] == 1'b1, "t2_ovf_at_17", overflow[0], 1);
      wait_idle(3000, "t2_drain");
      chk(out_cnt[0] == 16, "t2_delivered", out_cnt[0], 16);
      chk(overflow[0] == 1'b1, "t2_ovf_sticky", overflow[0], 1);
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      chk(overflow == '0, "t2_ovf_clr", overflow, 0);

      // Ten back-to-back events, out_clk 4x slower: no merging, no loss
      out_half = 20.0;
      do_reset();
      in_pulse = 4'b0001;
      repeat (10) step();
      in_pulse = '0;
      wait_idle(3000, "t3_drain");
      chk(out_cnt[0] == 10, "t3_delivered", out_cnt[0], 10);
      chk(overflow == '0, "t3_no_ovf", overflow, 0);

      // Channel independence
      out_half = 6.5;
      do_reset();
      in_pulse = 4'b1001;
      step();
      in_pulse = '0;
      step();
      step();
      in_pulse = 4'b0010;
      step();
      in_pulse = '0;
      wait_idle(500, "t4_drain");
      exp4 = '{1, 1, 0, 1};
      for (int ch = 0; ch < NUM_CH; ch++)
         chk(out_cnt[ch] == exp4[ch], $sformatf("t4_count_ch%0d", ch), out_cnt[ch], exp4[ch]);

      // Reset mid-transfer with a backlog of two
      out_half = 10.0;
      do_reset();
      in_pulse = 4'b0001;
      repeat (3) step();
      in_pulse = '0;
      chk(busy[0] == 1'b1, "t5_busy_before_reset", busy[0], 1);
      #2 rst_n = 1'b0;
      #1;
      chk({busy, overflow, out_pulse} == '0, "t5_outputs_in_reset",
          {busy, overflow, out_pulse}, 0);
      repeat (4) @(posedge in_clk);
      @(negedge in_clk);
      #1 rst_n = 1'b1;
      step();
      repeat (20) @(posedge out_clk);
      #1;
      chk((out_cnt[0] + out_cnt[1] + out_cnt[2] + out_cnt[3]) == 0, "t5_no_spurious",
          out_cnt[0] + out_cnt[1] + out_cnt[2] + out_cnt[3], 0);
      step();
      in_pulse = 4'b0001;
      step();
      in_pulse = '0;
      wait_idle(500, "t5_drain");
      chk(out_cnt[0] == 1, "t5_one_after_reset", out_cnt[0], 1);

      // Randomised density at 1:3, 1:1 and 3:1 clock ratios
      for (int r = 0; r < 3; r++) begin
         out_half = (r == 0) ? 15.0 : ((r == 1) ? 5.0 : 10.0 / 6.0);
         do_reset();
         for (int i = 0; i < 400; i++) begin
            if (i % 100 == 0) dens = $urandom_range(1, 5);
            for (int ch = 0; ch < NUM_CH; ch++)
               in_pulse[ch] = ($urandom_range(0, dens - 1) == 0);
            ovf_clr = ($urandom_range(0, 31) == 0);
            step();
         end
         in_pulse = '0;
         ovf_clr  = 1'b0;
         wait_idle(5000, $sformatf("t6_drain_r%0d", r));
         for (int ch = 0; ch < NUM_CH; ch++) begin
            if (!ovf_ever[ch])
               chk(out_cnt[ch] == in_cnt[ch], $sformatf("t6_conserve_r%0d_ch%0d", r, ch),
                   out_cnt[ch], in_cnt[ch]);
            else
               chk(out_cnt[ch] <= in_cnt[ch], $sformatf("t6_out_le_in_r%0d_ch%0d", r, ch),
                   out_cnt[ch], in_cnt[ch]);
         end
      end

      errors += cyc_err;
      checks += cyc_chk;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_pulse_sync_multi
`default_nettype wire
